game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 141 ++++++++++++++
 tb/tb_game_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
`default_nettype none
// game_sequencer: whack-a-mole game controller with start/pause/abort control,
// game-second and mole-spawn prescalers, and hit scoring locked once per mole period.
module game_sequencer #(
  parameter int TICK_DIV   = 100000000,
  parameter int GAME_SECS  = 30,
  parameter int SPAWN_DIV  = 50000000,
  parameter int WIN_SCORE  = 15,
  parameter int PASS_SCORE = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic       hit,
  output logic       mole_step,
  output logic       mole_en,
  output logic [3:0] score,
  output logic [5:0] time_left,
  output logic [2:0] state,
  output logic       win,
  output logic       lose
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SPAWN_MAX = SW'(SPAWN_DIV - 1);
  localparam logic [5:0]    SECS_INIT = 6'(GAME_SECS);
  localparam logic [3:0]    WIN_LVL   = 4'(WIN_SCORE);
  localparam logic [3:0]    PASS_LVL  = 4'(PASS_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      score_q, score_d;
  logic [5:0]      time_q, time_d;
  logic [TW-1:0]   sec_q, sec_d;
  logic [SW-1:0]   spawn_q, spawn_d;
  logic            lock_q, lock_d;
  logic            start_prev_q;

  logic            w_start_edge;
  logic            w_in_play;
  logic            w_tick;
  logic            w_hit_ok;
  logic [3:0]      w_score_inc;

  assign w_start_edge = start & ~start_prev_q;
  assign w_in_play    = (state_q == ST_PLAY);
  assign w_tick       = w_in_play && (sec_q == TICK_MAX);
  assign mole_step    = w_in_play && (spawn_q == SPAWN_MAX);
  assign w_hit_ok     = w_in_play && hit && !lock_q;
  assign w_score_inc  = (score_q == 4'd15) ? score_q : score_q + 4'd1;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    time_d  = time_q;
    sec_d   = sec_q;
    spawn_d = spawn_q;
    lock_d  = lock_q;

    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (w_start_edge) begin
          state_d = ST_PLAY;
          score_d = '0;
          time_d  = SECS_INIT;
          sec_d   = '0;
          spawn_d = '0;
          lock_d  = 1'b0;
        end
      end
      ST_PLAY: begin
        sec_d   = w_tick ? '0 : sec_q + TW'(1);
        spawn_d = mole_step ? '0 : spawn_q + SW'(1);
        if (w_hit_ok) score_d = w_score_inc;
        // A new mole re-arms the lock even when it coincides with a counted hit.
        lock_d  = mole_step ? 1'b0 : (w_hit_ok ? 1'b1 : lock_q);
        if (w_tick) time_d = time_q - 6'd1;
        if (score_d >= WIN_LVL)
          state_d = ST_WIN;
        else if (time_d == 6'd0)
          state_d = (score_d >= PASS_LVL) ? ST_WIN : ST_LOSE;
        else if (pause)
          state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (!pause) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      score_d = '0;
      time_d  = SECS_INIT;
      sec_d   = '0;
      spawn_d = '0;
      lock_d  = 1'b0;
    end
  end

  // start_prev resets high so a start held through reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      score_q      <= '0;
      time_q       <= SECS_INIT;
      sec_q        <= '0;
      spawn_q      <= '0;
      lock_q       <= 1'b0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      time_q       <= time_d;
      sec_q        <= sec_d;
      spawn_q      <= spawn_d;
      lock_q       <= lock_d;
      start_prev_q <= start;
    end
  end

  assign state     = state_q;
  assign score     = score_q;
  assign time_left = time_q;
  assign mole_en   = (state_q == ST_PLAY);
  assign win       = (state_q == ST_WIN);
  assign lose      = (state_q == ST_LOSE);

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// tb_game_sequencer: directed game scenarios plus randomized play, checked every
// cycle against a play-cycle-count reference model.
module tb_game_sequencer;

  localparam int TD = 4;
  localparam int GS = 3;
  localparam int SD = 3;
  localparam int WS = 4;
  localparam int PS = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b1;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       hit   = 1'b0;
  logic       mole_step, mole_en, win, lose;
  logic [3:0] score;
  logic [5:0] time_left;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state 0..4, score, and the number of PLAY cycles elapsed.
  int m_state = 0;
  int m_score = 0;
  int m_time  = GS;
  int m_pc    = 0;
  bit m_lock  = 1'b0;
  bit m_prev  = 1'b1;

  game_sequencer #(
    .TICK_DIV  (TD),
    .GAME_SECS (GS),
    .SPAWN_DIV (SD),
    .WIN_SCORE (WS),
    .PASS_SCORE(PS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .hit      (hit),
    .mole_step(mole_step),
    .mole_en  (mole_en),
    .score    (score),
    .time_left(time_left),
    .state    (state),
    .win      (win),
    .lose     (lose)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_time = GS; m_pc = 0; m_lock = 1'b0; m_prev = 1'b1;
  endtask

  task automatic model_step();
    bit edge_s;
    bit step_now;
    edge_s = start && !m_prev;
    m_prev = start;
    case (m_state)
      0, 3, 4: if (!abort && edge_s) begin
        m_state = 1; m_score = 0; m_time = GS; m_pc = 0; m_lock = 1'b0;
      end
      1: if (!abort) begin
        step_now = (m_pc % SD) == SD - 1;
        if (hit && !m_lock) begin
          if (m_score < 15) m_score++;
          m_lock = 1'b1;
        end
        if (step_now) m_lock = 1'b0;
        m_pc++;
        m_time = GS - m_pc / TD;
        if (m_score >= WS)     m_state = 3;
        else if (m_time == 0)  m_state = (m_score >= PS) ? 3 : 4;
        else if (pause)        m_state = 2;
      end
      2: if (!abort && !pause) m_state = 1;
      default: m_state = 0;
    endcase
    if (abort) begin
      m_state = 0; m_score = 0; m_time = GS;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    check("state",     state,     m_state);
    check("score",     score,     m_score);
    check("time_left", time_left, m_time);
    check("mole_en",   mole_en,   m_state == 1);
    check("win",       win,       m_state == 3);
    check("lose",      lose,      m_state == 4);
    check("mole_step", mole_step, (m_state == 1) && ((m_pc % SD) == SD - 1));
  end

  task automatic tick(input bit s, input bit p, input bit a, input bit h);
    start = s; pause = p; abort = a; hit = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(1, 0, 0, 0);
    check("lit_start_held_thru_reset", state, 0);

    // Basic game with no hits: timing of entry, first mole and decrements.
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("lit_play_entry_state", state, 1);
    check("lit_play_entry_time", time_left, 3);
    tick(1, 0, 0, 0);
    check("lit_no_step_cycle2", mole_step, 0);
    tick(1, 0, 0, 0);
    check("lit_first_mole_step", mole_step, 1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check("lit_first_decrement", time_left, 2);
    repeat (7) tick(0, 0, 0, 0);
    check("lit_still_play_pc11", state, 1);
    tick(0, 0, 0, 0);
    check("lit_lose_state", state, 4);
    check("lit_lose_flag", lose, 1);
    check("lit_lose_mole_en", mole_en, 0);
    check("lit_lose_time", time_left, 0);

    // One hit per mole period reaches WIN_SCORE.
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int p = 0; p < 10; p++) tick(0, 0, 0, (p % 3) == 0);
    check("lit_win_state", state, 3);
    check("lit_win_score", score, 4);
    check("lit_win_time", time_left, 1);
    repeat (5) tick(0, 0, 0, 1);
    check("lit_win_frozen_time", time_left, 1);
    check("lit_win_frozen_score", score, 4);

    // Hit lock within a mole period, and re-arm on a mole_step hit.
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    check("lit_double_hit_score", score, 1);
    tick(0, 0, 1, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    check("lit_step_hit_score", score, 1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    check("lit_rearm_score", score, 2);

    // Pause for 10 cycles starting at PLAY cycle 5.
    tick(0, 0, 1, 0);
    tick(1, 0, 0, 0);
    repeat (4) tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    check("lit_pause_state", state, 2);
    check("lit_pause_mole_en", mole_en, 0);
    tick(0, 1, 0, 1);
    check("lit_pause_hit_ignored", score, 0);
    repeat (8) tick(0, 1, 0, 0);
    check("lit_pause_time_held", time_left, 2);
    tick(0, 0, 0, 0);
    repeat (6) tick(0, 0, 0, 0);
    check("lit_pause_still_play", state, 1);
    tick(0, 0, 0, 0);
    check("lit_pause_lose_delayed", state, 4);

    // Abort during PAUSE.
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    check("lit_abort_state", state, 0);
    check("lit_abort_score", score, 0);
    check("lit_abort_time", time_left, 3);

    // Asynchronous reset mid-game.
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("lit_async_reset_state", state, 0);
    check("lit_async_reset_score", score, 0);
    check("lit_async_reset_time", time_left, 3);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      bit s, p;
      s = ($urandom_range(0, 7) == 0) ? ~start : start;
      p = ($urandom_range(0, 24) == 0) ? ~pause : pause;
      tick(s, p, $urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
